// File: rtl/lcd_panel_rx.sv
// Receive side of the 4-wire serial LCD link: deserialises bytes, decodes the command subset, streams RGB565 pixels.
// Latency: byte_valid/pixel_valid 3 cin cycles after the cin edge that first sees scl high for bit 0.
// No backpressure: every completed byte is decoded in the cycle it completes; outputs are pulses/held registers.
module lcd_panel_rx #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT)
) (
    input  logic          i_cin,
    input  logic          i_reset,
    input  logic          i_sda,
    input  logic          i_scl,
    input  logic          i_cs,
    input  logic          i_rs,
    output logic          o_byte_valid,
    output logic [7:0]    o_byte_data,
    output logic          o_byte_is_cmd,
    output logic          o_pixel_valid,
    output logic [15:0]   o_pixel,
    output logic [XW-1:0] o_px_x,
    output logic [YW-1:0] o_px_y,
    output logic          o_frame_start,
    output logic          o_sleeping,
    output logic          o_display_on
);

    typedef enum logic [2:0] {S_CMD, S_CASET, S_PASET, S_RAMWR, S_SKIP} state_t;

    localparam logic [15:0] W16 = 16'(WIDTH);
    localparam logic [15:0] H16 = 16'(HEIGHT);

    logic [1:0]    r_sda_s, r_scl_s, r_cs_s, r_rs_s;
    logic          r_scl_d, r_cs_d;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    state_t        r_state, w_state_nxt;
    logic [1:0]    r_pcnt;
    logic [7:0]    r_p0, r_p1, r_p2;
    logic [XW-1:0] r_xs, r_xe, r_x;
    logic [YW-1:0] r_ys, r_ye, r_y;
    logic          r_phase;   // 0: expecting hi byte, 1: expecting lo byte
    logic [7:0]    r_hi;

    logic          w_scl_rise, w_sel, w_shift, w_byte_done, w_is_cmd;
    logic [7:0]    w_byte;
    logic [15:0]   w_start, w_end;
    logic          w_win_ok;
    logic          w_sleep_set, w_sleep_clr, w_disp_set, w_disp_clr;
    logic          w_ram_start, w_param_store, w_win_commit, w_hi_load, w_pix_emit;

    // Two-flop synchronisers plus one delay stage for edge detection; cs idles deselected.
    always_ff @(posedge i_cin or posedge i_reset) begin
        if (i_reset) begin
            r_sda_s <= 2'b00;
            r_scl_s <= 2'b00;
            r_cs_s  <= 2'b11;
            r_rs_s  <= 2'b00;
            r_scl_d <= 1'b0;
            r_cs_d  <= 1'b1;
        end else begin
            r_sda_s <= {r_sda_s[0], i_sda};
            r_scl_s <= {r_scl_s[0], i_scl};
            r_cs_s  <= {r_cs_s[0], i_cs};
            r_rs_s  <= {r_rs_s[0], i_rs};
            r_scl_d <= r_scl_s[1];
            r_cs_d  <= r_cs_s[1];
        end
    end

    // Selected while cs is low, and also in the cycle cs rises so a byte finishing then still counts.
    assign w_scl_rise  = r_scl_s[1] & ~r_scl_d;
    assign w_sel       = ~r_cs_s[1] | ~r_cs_d;
    assign w_shift     = w_scl_rise & w_sel;
    assign w_byte_done = w_shift & (r_bitcnt == 3'd7);
    assign w_byte      = {r_shift[6:0], r_sda_s[1]};
    assign w_is_cmd    = ~r_rs_s[1];

    assign w_start  = {r_p0, r_p1};
    assign w_end    = {r_p2, w_byte};
    assign w_win_ok = (w_start <= w_end) && (w_end < ((r_state == S_CASET) ? W16 : H16));

    // Shift in sda on each selected scl rise; deselect discards a partial byte.
    always_ff @(posedge i_cin or posedge i_reset) begin
        if (i_reset) begin
            r_bitcnt <= 3'd0;
            r_shift  <= 8'h00;
        end else if (w_shift) begin
            r_bitcnt <= r_bitcnt + 3'd1;
            r_shift  <= w_byte;
        end else if (r_cs_s[1]) begin
            r_bitcnt <= 3'd0;
        end
    end

    // Decoder state register.
    always_ff @(posedge i_cin or posedge i_reset) begin
        if (i_reset) r_state <= S_CMD;
        else         r_state <= w_state_nxt;
    end

    // Next state and per-byte action strobes; commands preempt whatever state is active.
    always_comb begin
        w_state_nxt   = r_state;
        w_sleep_set   = 1'b0;
        w_sleep_clr   = 1'b0;
        w_disp_set    = 1'b0;
        w_disp_clr    = 1'b0;
        w_ram_start   = 1'b0;
        w_param_store = 1'b0;
        w_win_commit  = 1'b0;
        w_hi_load     = 1'b0;
        w_pix_emit    = 1'b0;
        if (w_byte_done) begin
            if (w_is_cmd) begin
                case (w_byte)
                    8'h11: begin w_sleep_clr = 1'b1; w_state_nxt = S_CMD; end
                    8'h10: begin w_sleep_set = 1'b1; w_state_nxt = S_CMD; end
                    8'h29: begin w_disp_set  = 1'b1; w_state_nxt = S_CMD; end
                    8'h28: begin w_disp_clr  = 1'b1; w_state_nxt = S_CMD; end
                    8'h2A: w_state_nxt = S_CASET;
                    8'h2B: w_state_nxt = S_PASET;
                    8'h2C: begin w_ram_start = 1'b1; w_state_nxt = S_RAMWR; end
                    default: w_state_nxt = S_SKIP;
                endcase
            end else begin
                case (r_state)
                    S_CASET, S_PASET: begin
                        w_param_store = 1'b1;
                        if (r_pcnt == 2'd3) begin
                            w_win_commit = w_win_ok;
                            w_state_nxt  = S_SKIP;
                        end
                    end
                    S_RAMWR: begin
                        if (r_phase) w_pix_emit = 1'b1;
                        else         w_hi_load  = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Byte reporting registers.
    always_ff @(posedge i_cin or posedge i_reset) begin
        if (i_reset) begin
            o_byte_valid  <= 1'b0;
            o_byte_data   <= 8'h00;
            o_byte_is_cmd <= 1'b0;
        end else begin
            o_byte_valid <= w_byte_done;
            if (w_byte_done) begin
                o_byte_data   <= w_byte;
                o_byte_is_cmd <= w_is_cmd;
            end
        end
    end

    // Mode flags, window parameters and the RAMWR pixel datapath.
    always_ff @(posedge i_cin or posedge i_reset) begin
        if (i_reset) begin
            o_sleeping    <= 1'b1;
            o_display_on  <= 1'b0;
            o_pixel_valid <= 1'b0;
            o_frame_start <= 1'b0;
            o_pixel       <= 16'h0000;
            o_px_x        <= '0;
            o_px_y        <= '0;
            r_pcnt        <= 2'd0;
            r_p0          <= 8'h00;
            r_p1          <= 8'h00;
            r_p2          <= 8'h00;
            r_xs          <= '0;
            r_xe          <= XW'(WIDTH - 1);
            r_ys          <= '0;
            r_ye          <= YW'(HEIGHT - 1);
            r_x           <= '0;
            r_y           <= '0;
            r_phase       <= 1'b0;
            r_hi          <= 8'h00;
        end else begin
            o_pixel_valid <= w_pix_emit;
            o_frame_start <= w_pix_emit && (r_x == r_xs) && (r_y == r_ys);
            if (w_sleep_set) o_sleeping   <= 1'b1;
            if (w_sleep_clr) o_sleeping   <= 1'b0;
            if (w_disp_set)  o_display_on <= 1'b1;
            if (w_disp_clr)  o_display_on <= 1'b0;

            if (w_byte_done && w_is_cmd) r_pcnt <= 2'd0;
            else if (w_param_store)      r_pcnt <= r_pcnt + 2'd1;

            if (w_param_store) begin
                case (r_pcnt)
                    2'd0:    r_p0 <= w_byte;
                    2'd1:    r_p1 <= w_byte;
                    2'd2:    r_p2 <= w_byte;
                    default: ;
                endcase
            end

            if (w_win_commit) begin
                if (r_state == S_CASET) begin
                    r_xs <= w_start[XW-1:0];
                    r_xe <= w_end[XW-1:0];
                end else begin
                    r_ys <= w_start[YW-1:0];
                    r_ye <= w_end[YW-1:0];
                end
            end

            if (w_ram_start) begin
                r_x     <= r_xs;
                r_y     <= r_ys;
                r_phase <= 1'b0;
            end

            if (w_hi_load) begin
                r_hi    <= w_byte;
                r_phase <= 1'b1;
            end

            // Emit at the current position, then advance with row and window wrap.
            if (w_pix_emit) begin
                o_pixel <= {r_hi, w_byte};
                o_px_x  <= r_x;
                o_px_y  <= r_y;
                r_phase <= 1'b0;
                if (r_x == r_xe) begin
                    r_x <= r_xs;
                    r_y <= (r_y == r_ye) ? r_ys : r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_panel_rx.sv
// Directed bench for lcd_panel_rx: bit-banged serial link, pixel capture queue, immediate-assertion checks.
// Inputs are driven on cin negedges; scl runs at cin/4.
// Every check reports FAIL with tag, observed and expected values.
module tb_lcd_panel_rx;

    logic        cin = 1'b0;
    logic        reset, sda, scl, cs, rs;
    logic        byte_valid, byte_is_cmd, pixel_valid, frame_start, sleeping, display_on;
    logic [7:0]  byte_data;
    logic [15:0] pixel;
    logic [8:0]  px_x;
    logic [7:0]  px_y;

    int checks = 0;
    int passed = 0;
    int bv_cnt = 0;
    logic [33:0] pix_q[$];

    lcd_panel_rx dut (
        .i_cin(cin), .i_reset(reset), .i_sda(sda), .i_scl(scl), .i_cs(cs), .i_rs(rs),
        .o_byte_valid(byte_valid), .o_byte_data(byte_data), .o_byte_is_cmd(byte_is_cmd),
        .o_pixel_valid(pixel_valid), .o_pixel(pixel), .o_px_x(px_x), .o_px_y(px_y),
        .o_frame_start(frame_start), .o_sleeping(sleeping), .o_display_on(display_on)
    );

    always #5 cin = ~cin;

    // Capture byte pulses and pixels away from the active edge.
    always @(negedge cin) begin
        if (byte_valid) bv_cnt++;
        if (pixel_valid) pix_q.push_back({frame_start, px_y, px_x, pixel});
    end

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_pix(input string tag, input int idx, input int x, input int y,
                           input logic [15:0] p, input logic fs);
        logic [33:0] e;
        logic [33:0] o;
        e = {fs, 8'(y), 9'(x), p};
        o = (idx < pix_q.size()) ? pix_q[idx] : 34'h3_FFFF_FFFF;
        chk(tag, {6'd0, o}, {6'd0, e});
    endtask

    task automatic send_bits(input logic [7:0] b, input logic r, input int n);
        cs = 1'b0;
        for (int i = 0; i < n; i++) begin
            sda = b[7-i];
            rs  = r;
            scl = 1'b0;
            repeat (2) @(negedge cin);
            scl = 1'b1;
            repeat (2) @(negedge cin);
        end
    endtask

    task automatic end_frame();
        scl = 1'b0;
        @(negedge cin);
        cs = 1'b1;
        repeat (3) @(negedge cin);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic r);
        send_bits(b, r, 8);
        end_frame();
    endtask

    task automatic cmd(input logic [7:0] b);
        send_byte(b, 1'b0);
    endtask

    task automatic dat(input logic [7:0] b);
        send_byte(b, 1'b1);
    endtask

    initial begin
        int base;
        int fs_cnt;
        int ex[7];
        int ey[7];
        logic efs[7];
        ex  = '{10, 11, 12, 10, 11, 12, 10};
        ey  = '{5, 5, 5, 6, 6, 6, 5};
        efs = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; cs = 1'b1; scl = 1'b0; sda = 1'b0; rs = 1'b0;
        repeat (3) @(negedge cin);
        // Reset state.
        chk("rst_flags", {byte_valid, pixel_valid, frame_start, byte_is_cmd, display_on, sleeping}, 40'b000001);
        chk("rst_data", {byte_data, pixel, px_x, px_y}, 40'd0);
        reset = 1'b0;
        repeat (2) @(negedge cin);

        // Command decode with exact latency on 0x11.
        send_bits(8'h11, 1'b0, 7);
        sda = 1'b1; rs = 1'b0; scl = 1'b0;
        repeat (2) @(negedge cin);
        scl = 1'b1;
        @(negedge cin);
        chk("lat_c1_bv", byte_valid, 0);
        chk("lat_c1_sleep", sleeping, 1);
        @(negedge cin);
        chk("lat_c2_bv", byte_valid, 0);
        @(negedge cin);
        chk("lat_c3_bv", byte_valid, 1);
        chk("lat_c3_byte", {byte_is_cmd, byte_data}, {1'b1, 8'h11});
        chk("lat_c3_sleep", sleeping, 0);
        @(negedge cin);
        chk("bv_pulse_width", byte_valid, 0);
        end_frame();
        cmd(8'h29);
        chk("disp_on", display_on, 1);
        chk("byte_29", {byte_is_cmd, byte_data}, {1'b1, 8'h29});
        chk("bv_count_2", bv_cnt, 2);

        // Windowed write with row and window wrap.
        pix_q.delete();
        cmd(8'h2A); dat(8'h00); dat(8'h0A); dat(8'h00); dat(8'h0C);
        cmd(8'h2B); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h06);
        cmd(8'h2C);
        for (int i = 0; i < 7; i++) begin dat(8'h12); dat(8'h34); end
        chk("win_count", pix_q.size(), 7);
        for (int i = 0; i < 7; i++) chk_pix($sformatf("win_pix%0d", i), i, ex[i], ey[i], 16'h1234, efs[i]);

        // Partial byte discarded, next byte decodes cleanly.
        base = bv_cnt;
        send_bits(8'hFF, 1'b1, 5);
        end_frame();
        chk("abort_no_bv", bv_cnt, base);
        cmd(8'h28);
        chk("abort_next_byte", {byte_is_cmd, byte_data}, {1'b1, 8'h28});
        chk("abort_disp_off", display_on, 0);

        // Dangling hi byte dropped by a new RAMWR.
        pix_q.delete();
        cmd(8'h2C); dat(8'hAB); cmd(8'h2C); dat(8'h56); dat(8'h78);
        chk("dangle_count", pix_q.size(), 1);
        chk_pix("dangle_pix", 0, 10, 5, 16'h5678, 1'b1);

        // Asynchronous reset in the middle of a pixel.
        cmd(8'h29); cmd(8'h11); cmd(8'h2C); dat(8'h9A);
        chk("pre_rst_flags", {display_on, sleeping}, 2'b10);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_flags", {byte_valid, pixel_valid, frame_start, byte_is_cmd, display_on, sleeping}, 40'b000001);
        chk("mid_rst_data", {byte_data, pixel, px_x, px_y}, 40'd0);
        repeat (2) @(negedge cin);
        reset = 1'b0;
        repeat (2) @(negedge cin);
        pix_q.delete();
        base = bv_cnt;
        dat(8'h12); dat(8'h34); dat(8'h56); dat(8'h78);
        chk("post_rst_bytes", bv_cnt - base, 4);
        chk("post_rst_no_pix", pix_q.size(), 0);
        chk("post_rst_byte", {byte_is_cmd, byte_data}, {1'b0, 8'h78});

        // Out-of-range end column leaves the previous window in place.
        cmd(8'h2A); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h07);
        cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h01); dat(8'h40);
        cmd(8'h2C); dat(8'hCA); dat(8'hFE);
        chk("badwin_count", pix_q.size(), 1);
        chk_pix("badwin_pix", 0, 5, 0, 16'hCAFE, 1'b1);

        // Full-width row: end = WIDTH-1 is accepted, row wraps to column 0.
        pix_q.delete();
        cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h01); dat(8'h3F);
        cmd(8'h2C);
        for (int i = 0; i < 321; i++) begin
            logic [15:0] v;
            v = 16'(i);
            dat(v[15:8]);
            dat(v[7:0]);
        end
        chk("full_count", pix_q.size(), 321);
        chk_pix("full_first", 0, 0, 0, 16'h0000, 1'b1);
        chk_pix("full_row_end", 319, 319, 0, 16'h013F, 1'b0);
        chk_pix("full_next_row", 320, 0, 1, 16'h0140, 1'b0);
        fs_cnt = 0;
        foreach (pix_q[i]) if (pix_q[i][33]) fs_cnt++;
        chk("full_fs_count", fs_cnt, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
